// File: rtl/mc_pkg.sv
// ============================================================================
// Module : mc_pkg
// Brief  : State, opcode and control-field encodings for the multi-cycle
//          MIPS main controller. Config macro: MC_JUMP_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_B       = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Dispatch target out of DECODE; S_FETCH means the opcode is not supported.
    function automatic state_t decode_target(input logic [5:0] op);
        case (op)
            OP_RTYPE:     return S_R_EXEC;
            OP_LW, OP_SW: return S_MEM_ADDR;
            OP_BEQ:       return S_BRANCH;
`ifdef MC_JUMP_EN
            OP_J:         return S_JUMP;
`endif
            default:      return S_FETCH;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control_if.sv
// ============================================================================
// Module : multicycle_control_if
// Brief  : Controller <-> datapath bundle: opcode/handshake in, enables out.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       mem_timeout;
    logic [3:0] state_o;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, mem_timeout, state_o
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, mem_timeout, state_o
    );
endinterface

`default_nettype wire

// File: rtl/mc_output_decode.sv
// ============================================================================
// Module : mc_output_decode
// Brief  : State (+mem_ready) to datapath control decode. Config: MC_JUMP_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_output_decode
    import mc_pkg::*;
(
    input  state_t     i_state,
    input  logic       i_mem_ready,
    output logic       o_pc_write,
    output logic       o_pc_write_cond,
    output logic       o_ior_d,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_mem_to_reg,
    output logic       o_reg_dst,
    output logic       o_reg_write,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_pc_source
);

    always_comb begin
        o_pc_write      = 1'b0;
        o_pc_write_cond = 1'b0;
        o_ior_d         = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_ir_write      = 1'b0;
        o_mem_to_reg    = 1'b0;
        o_reg_dst       = 1'b0;
        o_reg_write     = 1'b0;
        o_alu_src_a     = 1'b0;
        o_alu_src_b     = ALUSRCB_B;
        o_alu_op        = ALUOP_ADD;
        o_pc_source     = PCSRC_ALU;
        case (i_state)
            S_FETCH: begin
                // IR and PC+4 commit only on the cycle the fetch completes
                o_mem_read  = 1'b1;
                o_alu_src_b = ALUSRCB_FOUR;
                o_alu_op    = ALUOP_ADD;
                o_ir_write  = i_mem_ready;
                o_pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_alu_src_b = ALUSRCB_IMM_SH2;
                o_alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = ALUSRCB_IMM;
                o_alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                o_mem_read = 1'b1;
                o_ior_d    = 1'b1;
            end
            S_MEM_WRITE: begin
                o_mem_write = 1'b1;
                o_ior_d     = 1'b1;
            end
            S_MEM_WB: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
                o_reg_dst    = 1'b0;
            end
            S_R_EXEC: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                o_reg_write = 1'b1;
                o_reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                o_alu_src_a     = 1'b1;
                o_alu_op        = ALUOP_SUB;
                o_pc_write_cond = 1'b1;
                o_pc_source     = PCSRC_ALUOUT;
            end
`ifdef MC_JUMP_EN
            S_JUMP: begin
                o_pc_write  = 1'b1;
                o_pc_source = PCSRC_JUMP;
            end
`endif
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module : multicycle_control
// Brief  : Multi-cycle MIPS main control FSM with memory wait timeout.
//          Config macro: MC_JUMP_EN (enables the j instruction).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control
    import mc_pkg::*;
#(
    parameter int WAIT_LIMIT = 0,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);

    localparam bit             c_TIMEOUT_EN = (WAIT_LIMIT > 0);
    localparam logic [CNT_W-1:0] c_LIMIT_M1 = CNT_W'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

    state_t           r_state;
    state_t           w_next;
    logic [5:0]       r_opcode;
    logic [CNT_W-1:0] r_cnt;
    logic             w_limit_hit;
    logic             w_timeout;
    logic             w_illegal;
    logic             w_hold;

    // mem_ready on the limit cycle wins, so the limit only fires while ready is low
    assign w_limit_hit = c_TIMEOUT_EN && (r_cnt == c_LIMIT_M1) && !bus.mem_ready;

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        w_illegal = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (bus.mem_ready) begin
                    w_next = S_DECODE;
                end else if (w_limit_hit) begin
                    w_next    = S_FETCH;
                    w_timeout = 1'b1;
                end
            end
            S_DECODE: begin
                w_next    = decode_target(bus.opcode);
                w_illegal = (w_next == S_FETCH);
            end
            S_MEM_ADDR: w_next = (r_opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: begin
                if (bus.mem_ready) begin
                    w_next = S_MEM_WB;
                end else if (w_limit_hit) begin
                    w_next    = S_FETCH;
                    w_timeout = 1'b1;
                end
            end
            S_MEM_WRITE: begin
                if (bus.mem_ready) begin
                    w_next = S_FETCH;
                end else if (w_limit_hit) begin
                    w_next    = S_FETCH;
                    w_timeout = 1'b1;
                end
            end
            S_R_EXEC: w_next = S_R_WB;
            default:  w_next = S_FETCH;
        endcase
    end

    // Counter runs only while a memory state is held; any entry clears it.
    assign w_hold = (w_next == r_state) && !w_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_FETCH;
            r_opcode <= OP_RTYPE;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_hold ? r_cnt + 1'b1 : '0;
            if (r_state == S_DECODE) begin
                r_opcode <= bus.opcode;
            end
        end
    end

    mc_output_decode u_output_decode (
        .i_state         (r_state),
        .i_mem_ready     (bus.mem_ready),
        .o_pc_write      (bus.pc_write),
        .o_pc_write_cond (bus.pc_write_cond),
        .o_ior_d         (bus.ior_d),
        .o_mem_read      (bus.mem_read),
        .o_mem_write     (bus.mem_write),
        .o_ir_write      (bus.ir_write),
        .o_mem_to_reg    (bus.mem_to_reg),
        .o_reg_dst       (bus.reg_dst),
        .o_reg_write     (bus.reg_write),
        .o_alu_src_a     (bus.alu_src_a),
        .o_alu_src_b     (bus.alu_src_b),
        .o_alu_op        (bus.alu_op),
        .o_pc_source     (bus.pc_source)
    );

    assign bus.illegal_op  = w_illegal;
    assign bus.mem_timeout = w_timeout;
    assign bus.state_o     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module : tb_multicycle_control
// Brief  : Directed bench; an unlimited-wait and a WAIT_LIMIT=4 controller
//          share stimulus. Honors MC_JUMP_EN for the j expectations.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    int         n_tests;
    int         n_fail;

    multicycle_control_if bus0 ();
    multicycle_control_if bus4 ();

    assign bus0.opcode    = opcode;
    assign bus0.mem_ready = mem_ready;
    assign bus4.opcode    = opcode;
    assign bus4.mem_ready = mem_ready;

    multicycle_control #(.WAIT_LIMIT(0), .CNT_W(8)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.master)
    );

    multicycle_control #(.WAIT_LIMIT(4), .CNT_W(8)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        opcode    = 6'b000000;
        mem_ready = 1'b0;
        #3;
        chk("rst_state",     bus0.state_o,   0);
        chk("rst_mem_read",  bus0.mem_read,  1);
        chk("rst_alu_src_b", bus0.alu_src_b, 1);
        chk("rst_ir_write",  bus0.ir_write,  0);
        chk("rst_mem_write", bus0.mem_write, 0);
        chk("rst_reg_write", bus0.reg_write, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // R-type, 4 cycles
        opcode = 6'b000000; mem_ready = 1'b1; #1;
        chk("r_fetch_state", bus0.state_o,  0);
        chk("r_fetch_irw",   bus0.ir_write, 1);
        chk("r_fetch_pcw",   bus0.pc_write, 1);
        cyc(); #1;
        chk("r_dec_state",   bus0.state_o,   1);
        chk("r_dec_srcb",    bus0.alu_src_b, 3);
        cyc(); #1;
        chk("r_exec_state",  bus0.state_o,   6);
        chk("r_exec_aluop",  bus0.alu_op,    2);
        chk("r_exec_srca",   bus0.alu_src_a, 1);
        cyc(); #1;
        chk("r_wb_state",    bus0.state_o,   7);
        chk("r_wb_regw",     bus0.reg_write, 1);
        chk("r_wb_regdst",   bus0.reg_dst,   1);
        cyc(); #1;
        chk("r_done_state",  bus0.state_o,   0);

        // lw with mem_ready low for three MEM_READ cycles, ready on the 4th
        opcode = 6'b100011; mem_ready = 1'b1;
        cyc(); #1;
        chk("lw_dec_state",  bus0.state_o, 1);
        cyc(); #1;
        chk("lw_addr_state", bus0.state_o,   2);
        chk("lw_addr_srcb",  bus0.alu_src_b, 2);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("lw_rd_state",  bus0.state_o,   3);
            chk("lw_rd_iord",   bus0.ior_d,     1);
            chk("lw_rd_regw",   bus0.reg_write, 0);
        end
        cyc();
        mem_ready = 1'b1; #1;
        chk("lw_rd4_state",   bus4.state_o,     3);
        chk("lw_rd4_timeout", bus4.mem_timeout, 0);
        cyc(); #1;
        chk("lw_wb_state",   bus0.state_o,    4);
        chk("lw_wb4_state",  bus4.state_o,    4);
        chk("lw_wb_regw",    bus0.reg_write,  1);
        chk("lw_wb_m2r",     bus0.mem_to_reg, 1);
        chk("lw_wb_regdst",  bus0.reg_dst,    0);
        cyc(); #1;
        chk("lw_done_state", bus0.state_o, 0);

        // beq
        opcode = 6'b000100;
        cyc(); cyc(); #1;
        chk("beq_state",    bus0.state_o,       8);
        chk("beq_aluop",    bus0.alu_op,        1);
        chk("beq_pwc",      bus0.pc_write_cond, 1);
        chk("beq_pcsrc",    bus0.pc_source,     1);
        cyc(); #1;
        chk("beq_done",     bus0.state_o, 0);

        // illegal opcode
        opcode = 6'b111111;
        cyc(); #1;
        chk("ill_state",    bus0.state_o,    1);
        chk("ill_pulse",    bus0.illegal_op, 1);
        chk("ill_regw",     bus0.reg_write,  0);
        chk("ill_memw",     bus0.mem_write,  0);
        chk("ill_pcw",      bus0.pc_write,   0);
        cyc(); #1;
        chk("ill_next",     bus0.state_o,    0);
        chk("ill_clear",    bus0.illegal_op, 0);

        // j
        opcode = 6'b000010;
        cyc(); #1;
`ifdef MC_JUMP_EN
        chk("j_dec_ill",    bus0.illegal_op, 0);
        cyc(); #1;
        chk("j_state",      bus0.state_o,   9);
        chk("j_pcw",        bus0.pc_write,  1);
        chk("j_pcsrc",      bus0.pc_source, 2);
`else
        chk("j_dec_ill",    bus0.illegal_op, 1);
`endif
        cyc(); #1;
        chk("j_done",       bus0.state_o, 0);

        // sw with memory never ready: limit-4 DUT times out, unlimited DUT holds
        opcode = 6'b101011;
        cyc(); cyc(); #1;
        chk("sw_addr_state", bus0.state_o, 2);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("sw_wr_state",  bus4.state_o,     5);
            chk("sw_wr_memw",   bus4.mem_write,   1);
            chk("sw_wr_noto",   bus4.mem_timeout, 0);
        end
        cyc(); #1;
        chk("sw_to_pulse",  bus4.mem_timeout, 1);
        chk("sw_to_regw",   bus4.reg_write,   0);
        chk("sw0_no_to",    bus0.mem_timeout, 0);
        cyc(); #1;
        chk("sw_to_fetch",  bus4.state_o,     0);
        chk("sw_to_clear",  bus4.mem_timeout, 0);
        chk("sw0_hold",     bus0.state_o,     5);
        chk("sw0_memw",     bus0.mem_write,   1);

        // async reset in the middle of MEM_WRITE
        rst_n = 1'b0; #1;
        chk("arst_memw",    bus0.mem_write, 0);
        chk("arst_state",   bus0.state_o,   0);
        @(negedge clk);
        rst_n = 1'b1; #1;
        chk("arst_rel_state", bus0.state_o, 0);

        // fetch stall: limit-4 DUT times out on the 4th FETCH cycle without IR write
        cyc(); cyc(); cyc(); #1;
        chk("fetch_to_pulse", bus4.mem_timeout, 1);
        chk("fetch_to_irw",   bus4.ir_write,    0);
        chk("fetch0_no_to",   bus0.mem_timeout, 0);
        cyc(); #1;
        chk("fetch_to_state", bus4.state_o,     0);
        chk("fetch_to_clear", bus4.mem_timeout, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
